// File: rtl/serial_parallel_conv_if.sv
// Bus-side signal bundle for serial_parallel_conv: master is the controller /
// bus top level, slave is the converter itself.
interface serial_parallel_conv_if #(
  parameter int DATA_WIDTH = 14,
  parameter int LEN_WIDTH  = 4
);
  logic                  dv_in;
  logic                  mode;
  logic [LEN_WIDTH-1:0]  bit_lngt;
  logic [DATA_WIDTH-1:0] par_in;
  logic [DATA_WIDTH-1:0] par_out;
  logic                  par_oe;
  logic                  ser_in;
  logic                  ser_out;
  logic                  ser_oe;
  logic                  busy;
  logic                  dv_out;
  logic                  parity_err;

  modport master (
    output dv_in, mode, bit_lngt, par_in, ser_in,
    input  par_out, par_oe, ser_out, ser_oe, busy, dv_out, parity_err
  );

  modport slave (
    input  dv_in, mode, bit_lngt, par_in, ser_in,
    output par_out, par_oe, ser_out, ser_oe, busy, dv_out, parity_err
  );
endinterface

// File: rtl/serial_parallel_conv.sv
// Bidirectional serial/parallel converter with per-transfer mode and length.
// Define SPC_PARITY_EN to append/check an even-parity bit after the data bits.
module serial_parallel_conv #(
  parameter int DATA_WIDTH = 14,
  parameter int LEN_WIDTH  = 4,
  parameter bit MSB_FIRST  = 1'b1
) (
  input logic                   clk,
  input logic                   rstn,
  serial_parallel_conv_if.slave bus
);

  localparam logic [LEN_WIDTH-1:0] DW_L  = LEN_WIDTH'(DATA_WIDTH);
  localparam logic [LEN_WIDTH-1:0] ONE_L = LEN_WIDTH'(1);
  localparam logic [LEN_WIDTH-1:0] TWO_L = LEN_WIDTH'(2);

`ifdef SPC_PARITY_EN
  typedef enum logic [2:0] {IDLE, TX, RX, TXP, RXP} state_t;
`else
  typedef enum logic [1:0] {IDLE, TX, RX} state_t;
`endif

  state_t                state, next_state;
  logic [DATA_WIDTH-1:0] tx_sreg, rx_sreg, rx_base, rx_shift_next;
  logic [DATA_WIDTH-1:0] rx_word_src, rx_word, par_out_r;
  logic [LEN_WIDTH-1:0]  cnt, n_reg, n_eff, len_cur;
  logic                  par_oe_r, dv_out_r, parity_err_r;
  logic                  accept_tx, accept_rx, tx_done, rx_done;
  logic                  ser_out_c, ser_oe_c;
`ifdef SPC_PARITY_EN
  logic                  tx_par, rx_par;
`endif

  // A length of zero or anything wider than the word means a full word.
  assign n_eff = (bus.bit_lngt == '0 || bus.bit_lngt > DW_L) ? DW_L : bus.bit_lngt;

  // The receive shifter restarts from zero on the accept edge, so bit 0 can
  // be captured on the same edge that samples dv_in.
  assign rx_base       = accept_rx ? '0 : rx_sreg;
  assign rx_shift_next = MSB_FIRST ? {rx_base[DATA_WIDTH-2:0], bus.ser_in}
                                   : {bus.ser_in, rx_base[DATA_WIDTH-1:1]};
  assign len_cur       = accept_rx ? n_eff : n_reg;
`ifdef SPC_PARITY_EN
  assign rx_word_src   = (state == RXP) ? rx_sreg : rx_shift_next;
`else
  assign rx_word_src   = rx_shift_next;
`endif
  // LSB-first words collect at the top of the shifter and are right-aligned here.
  assign rx_word       = MSB_FIRST ? rx_word_src : (rx_word_src >> (DW_L - len_cur));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    accept_tx  = 1'b0;
    accept_rx  = 1'b0;
    tx_done    = 1'b0;
    rx_done    = 1'b0;
    ser_oe_c   = 1'b0;
    ser_out_c  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.dv_in && !bus.mode) begin
          accept_tx  = 1'b1;
          next_state = TX;
        end else if (bus.dv_in && bus.mode) begin
          accept_rx = 1'b1;
`ifdef SPC_PARITY_EN
          next_state = (n_eff == ONE_L) ? RXP : RX;
`else
          if (n_eff == ONE_L) rx_done = 1'b1;
          else                next_state = RX;
`endif
        end
      end
      TX: begin
        ser_oe_c  = 1'b1;
        ser_out_c = MSB_FIRST ? tx_sreg[DATA_WIDTH-1] : tx_sreg[0];
        if (cnt == '0) begin
`ifdef SPC_PARITY_EN
          next_state = TXP;
`else
          next_state = IDLE;
          tx_done    = 1'b1;
`endif
        end
      end
      RX: begin
        if (cnt == '0) begin
`ifdef SPC_PARITY_EN
          next_state = RXP;
`else
          next_state = IDLE;
          rx_done    = 1'b1;
`endif
        end
      end
`ifdef SPC_PARITY_EN
      TXP: begin
        ser_oe_c   = 1'b1;
        ser_out_c  = tx_par;
        next_state = IDLE;
        tx_done    = 1'b1;
      end
      RXP: begin
        next_state = IDLE;
        rx_done    = 1'b1;
      end
`endif
      default: next_state = IDLE;
    endcase
  end

  // The shared counter holds the number of bits still to move after the current one.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_sreg      <= '0;
      rx_sreg      <= '0;
      cnt          <= '0;
      n_reg        <= '0;
      par_out_r    <= '0;
      par_oe_r     <= 1'b0;
      dv_out_r     <= 1'b0;
      parity_err_r <= 1'b0;
`ifdef SPC_PARITY_EN
      tx_par       <= 1'b0;
      rx_par       <= 1'b0;
`endif
    end else begin
      dv_out_r <= tx_done | rx_done;
      if (accept_tx) begin
        tx_sreg  <= MSB_FIRST ? (bus.par_in << (DW_L - n_eff)) : bus.par_in;
        cnt      <= n_eff - ONE_L;
        par_oe_r <= 1'b0;
`ifdef SPC_PARITY_EN
        tx_par   <= ^(bus.par_in & ~({DATA_WIDTH{1'b1}} << n_eff));
`endif
      end else if (state == TX) begin
        tx_sreg <= MSB_FIRST ? (tx_sreg << 1) : (tx_sreg >> 1);
        cnt     <= cnt - ONE_L;
      end else if (accept_rx || state == RX) begin
        rx_sreg <= rx_shift_next;
        cnt     <= accept_rx ? (n_eff - TWO_L) : (cnt - ONE_L);
`ifdef SPC_PARITY_EN
        rx_par  <= (accept_rx ? 1'b0 : rx_par) ^ bus.ser_in;
`endif
      end
      if (accept_rx) n_reg <= n_eff;
      if (rx_done) begin
        par_out_r    <= rx_word;
        par_oe_r     <= 1'b1;
`ifdef SPC_PARITY_EN
        parity_err_r <= bus.ser_in ^ rx_par;
`else
        parity_err_r <= 1'b0;
`endif
      end
    end
  end

  assign bus.ser_out    = ser_out_c;
  assign bus.ser_oe     = ser_oe_c;
  assign bus.busy       = (state != IDLE);
  assign bus.dv_out     = dv_out_r;
  assign bus.par_out    = par_out_r;
  assign bus.par_oe     = par_oe_r;
  assign bus.parity_err = parity_err_r;

endmodule

// File: tb/tb_serial_parallel_conv.sv
// Directed self-checking bench for serial_parallel_conv (DATA_WIDTH=14, MSB first).
// Vectors give the line sequence as a word whose bit n-1 is the first bit on the line.
module tb_serial_parallel_conv;

  localparam int DW = 14;
  localparam int LW = 4;

  typedef struct {
    logic          mode;
    logic [LW-1:0] len;
    logic [DW-1:0] par_in;
    int            n;
    logic [DW-1:0] line;
    logic [DW-1:0] exp_par;
  } vec_t;

  logic clk = 1'b0;
  logic rstn;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  serial_parallel_conv_if #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();

  serial_parallel_conv #(
    .DATA_WIDTH(DW),
    .LEN_WIDTH (LW),
    .MSB_FIRST (1'b1)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic dv, input logic md, input logic [LW-1:0] len,
                               input logic [DW-1:0] par, input logic ser);
    bus.dv_in    = dv;
    bus.mode     = md;
    bus.bit_lngt = len;
    bus.par_in   = par;
    bus.ser_in   = ser;
  endtask

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic checkBit(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  // Ends in the dv_out cycle with inputs idle, so a following call is back-to-back.
  // inject_at >= 0 raises an S2P request in that bit cycle, which must be ignored.
  task automatic runTx(input string name, input logic [LW-1:0] len, input logic [DW-1:0] par,
                       input int n, input logic [DW-1:0] line, input int inject_at);
    applyStimulus(1'b1, 1'b0, len, par, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);
    for (int i = 0; i < n; i++) begin
      checkBit($sformatf("%s ser_out bit %0d", name, i), bus.ser_out, line[n-1-i]);
      checkBit($sformatf("%s ser_oe bit %0d", name, i), bus.ser_oe, 1'b1);
      checkBit($sformatf("%s busy bit %0d", name, i), bus.busy, 1'b1);
      checkBit($sformatf("%s dv_out bit %0d", name, i), bus.dv_out, 1'b0);
      if (i == inject_at) applyStimulus(1'b1, 1'b1, 4'd3, 14'h3FFF, 1'b1);
      else                applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);
      tick();
    end
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);
`ifdef SPC_PARITY_EN
    checkBit({name, " parity bit"}, bus.ser_out, ^line);
    checkBit({name, " parity oe"}, bus.ser_oe, 1'b1);
    tick();
`endif
    checkBit({name, " dv_out"}, bus.dv_out, 1'b1);
    checkBit({name, " ser_oe end"}, bus.ser_oe, 1'b0);
    checkBit({name, " ser_out end"}, bus.ser_out, 1'b0);
    checkBit({name, " busy end"}, bus.busy, 1'b0);
    checkBit({name, " par_oe"}, bus.par_oe, 1'b0);
  endtask

  task automatic runRx(input string name, input logic [LW-1:0] len, input int n,
                       input logic [DW-1:0] line, input logic [DW-1:0] exp_par);
    applyStimulus(1'b1, 1'b1, len, '0, line[n-1]);
    tick();
    for (int i = 1; i < n; i++) begin
      checkBit($sformatf("%s busy bit %0d", name, i), bus.busy, 1'b1);
      checkBit($sformatf("%s dv_out bit %0d", name, i), bus.dv_out, 1'b0);
      applyStimulus(1'b0, 1'b1, '0, '0, line[n-1-i]);
      tick();
    end
`ifdef SPC_PARITY_EN
    checkBit({name, " busy parity"}, bus.busy, 1'b1);
    applyStimulus(1'b0, 1'b1, '0, '0, ^line);
    tick();
`endif
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);
    checkBit({name, " dv_out"}, bus.dv_out, 1'b1);
    checkBit({name, " par_oe"}, bus.par_oe, 1'b1);
    checkBit({name, " busy end"}, bus.busy, 1'b0);
    checkBit({name, " parity_err"}, bus.parity_err, 1'b0);
    checkOutput({name, " par_out"}, bus.par_out, exp_par);
  endtask

  task automatic checkIdle(input string name, input logic exp_oe);
    checkBit({name, " idle dv_out"}, bus.dv_out, 1'b0);
    checkBit({name, " idle busy"}, bus.busy, 1'b0);
    checkBit({name, " idle ser_oe"}, bus.ser_oe, 1'b0);
    checkBit({name, " idle par_oe"}, bus.par_oe, exp_oe);
  endtask

  initial begin
    vec_t vecs [11];
    vecs[0]  = '{1'b0, 4'd4,  14'h000B, 4,  14'h000B, 14'h0000};
    vecs[1]  = '{1'b0, 4'd0,  14'h2A5C, 14, 14'h2A5C, 14'h0000};
    vecs[2]  = '{1'b0, 4'd15, 14'h1234, 14, 14'h1234, 14'h0000};
    vecs[3]  = '{1'b0, 4'd1,  14'h3FFE, 1,  14'h0000, 14'h0000};
    vecs[4]  = '{1'b0, 4'd8,  14'h3FA5, 8,  14'h00A5, 14'h0000};
    vecs[5]  = '{1'b1, 4'd0,  14'h0000, 14, 14'h2A5C, 14'h2A5C};
    vecs[6]  = '{1'b1, 4'd1,  14'h0000, 1,  14'h0001, 14'h0001};
    vecs[7]  = '{1'b1, 4'd5,  14'h0000, 5,  14'h0013, 14'h0013};
    vecs[8]  = '{1'b1, 4'd14, 14'h0000, 14, 14'h3FFF, 14'h3FFF};
    vecs[9]  = '{1'b1, 4'd2,  14'h0000, 2,  14'h0002, 14'h0002};
    vecs[10] = '{1'b1, 4'd9,  14'h0000, 9,  14'h0155, 14'h0155};

    rstn = 1'b0;
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);
    tick();
    tick();
    checkBit("reset ser_out", bus.ser_out, 1'b0);
    checkBit("reset ser_oe", bus.ser_oe, 1'b0);
    checkBit("reset busy", bus.busy, 1'b0);
    checkBit("reset dv_out", bus.dv_out, 1'b0);
    checkBit("reset par_oe", bus.par_oe, 1'b0);
    checkBit("reset parity_err", bus.parity_err, 1'b0);
    checkOutput("reset par_out", bus.par_out, '0);
    rstn = 1'b1;
    tick();

    for (int v = 0; v < 11; v++) begin
      if (vecs[v].mode)
        runRx($sformatf("vec%0d", v), vecs[v].len, vecs[v].n, vecs[v].line, vecs[v].exp_par);
      else
        runTx($sformatf("vec%0d", v), vecs[v].len, vecs[v].par_in, vecs[v].n, vecs[v].line, -1);
      tick();
      checkIdle($sformatf("vec%0d", v), vecs[v].mode);
    end

    // Request during a transfer is dropped; request in the dv_out cycle is taken.
    runTx("busyIgnore", 4'd8, 14'h00C3, 8, 14'h00C3, 2);
    runTx("backToBack", 4'd8, 14'h00B4, 8, 14'h00B4, -1);
    tick();
    checkIdle("backToBack", 1'b0);

    // Received word holds until a P2S accept clears par_oe.
    runRx("rxHold", 4'd5, 5, 14'h0013, 14'h0013);
    tick();
    tick();
    checkBit("rxHold held par_oe", bus.par_oe, 1'b1);
    checkOutput("rxHold held par_out", bus.par_out, 14'h0013);
    runTx("clearOe", 4'd2, 14'h0002, 2, 14'h0002, -1);
    tick();
    runRx("rxB2B1", 4'd3, 3, 14'h0005, 14'h0005);
    runRx("rxB2B2", 4'd6, 6, 14'h0032, 14'h0032);
    tick();
    checkIdle("rxB2B2", 1'b1);

    // Asynchronous reset in the middle of an 8-bit P2S.
    applyStimulus(1'b1, 1'b0, 4'd8, 14'h00FF, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);
    tick();
    tick();
    checkBit("preReset ser_out", bus.ser_out, 1'b1);
    rstn = 1'b0;
    #1;
    checkBit("midReset ser_out", bus.ser_out, 1'b0);
    checkBit("midReset ser_oe", bus.ser_oe, 1'b0);
    checkBit("midReset busy", bus.busy, 1'b0);
    checkBit("midReset dv_out", bus.dv_out, 1'b0);
    checkBit("midReset par_oe", bus.par_oe, 1'b0);
    checkBit("midReset parity_err", bus.parity_err, 1'b0);
    checkOutput("midReset par_out", bus.par_out, '0);
    tick();
    rstn = 1'b1;
    tick();
    runRx("afterReset", 4'd4, 4, 14'h0009, 14'h0009);
    tick();
    runTx("afterResetTx", 4'd4, 14'h000B, 4, 14'h000B, -1);
    tick();

`ifdef SPC_PARITY_EN
    // Data 1,1,0,1 has odd weight, so a received parity 0 is an error.
    for (int k = 0; k < 2; k++) begin
      logic [4:0] seq;
      seq = (k == 0) ? 5'b11010 : 5'b11011;
      applyStimulus(1'b1, 1'b1, 4'd4, '0, seq[4]);
      tick();
      for (int i = 3; i >= 0; i--) begin
        applyStimulus(1'b0, 1'b1, '0, '0, seq[i]);
        tick();
      end
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);
      checkBit($sformatf("parity%0d dv_out", k), bus.dv_out, 1'b1);
      checkBit($sformatf("parity%0d parity_err", k), bus.parity_err, (k == 0));
      checkOutput($sformatf("parity%0d par_out", k), bus.par_out, 14'h000D);
      tick();
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/serial_parallel_conv.md
# serial_parallel_conv

Parametrised bidirectional serial/parallel converter for the ABruTECH bus, the next generation of the fixed-width two-way converter. It serialises a parallel word onto a one-bit line or deserialises a one-bit stream into a parallel word, chosen per transfer by a mode input. Transfer length is selectable per transfer. It exposes separate in/out/output-enable signals so the bus top level owns all tri-state drivers. It sits between bus-master/slave controllers and the physical serial bus line.

## Interface
- DATA_WIDTH, 14, maximum word width in bits (≥2)
- LEN_WIDTH, 4, width of bit_lngt; must satisfy 2^LEN_WIDTH > DATA_WIDTH
- MSB_FIRST, 1, 1: word MSB on the line first; 0: LSB first
- clk  in  1  single clock; all logic on rising edge
- rstn  in  1  asynchronous active-low reset
- dv_in  in  1  start request, 1-cycle qualifier for par_in / first serial bit
- mode  in  1  0: parallel→serial (P2S); 1: serial→parallel (S2P); sampled with dv_in
- bit_lngt  in  LEN_WIDTH  bits to transfer N; 0 or >DATA_WIDTH means DATA_WIDTH; sampled with dv_in
- par_in  in  DATA_WIDTH  word to send, right-aligned (bits [N-1:0] used)
- par_out  out  DATA_WIDTH  received word, right-aligned, upper bits 0
- par_oe  out  1  par_out valid/drive enable
- ser_in  in  1  serial line input
- ser_out  out  1  serial line data
- ser_oe  out  1  serial line drive enable
- busy  out  1  transfer in progress; dv_in ignored while high
- dv_out  out  1  1-cycle completion pulse
- parity_err  out  1  S2P parity mismatch (see Configuration)

## Operation
- States: IDLE, TX (shifting out), RX (shifting in), TXP/RXP (parity bit, only with macro).
- IDLE + dv_in=1, mode=0: latch par_in and N into shift register/counter → TX.
- IDLE + dv_in=1, mode=1: sample ser_in as bit 0 on the same edge; if N=1 finish immediately, else → RX.
- TX: ser_oe=1, ser_out = current bit; counter decrements each edge; after bit N-1 → IDLE (or TXP).
- RX: sample ser_in each edge; after bit N-1 → IDLE (or RXP), load par_out, set par_oe.
- Bit order: MSB_FIRST=1 sends/receives par[N-1] first, par[0] last; MSB_FIRST=0 the reverse.
- par_out/par_oe hold until the next accepted S2P transfer completes; an accepted P2S transfer clears par_oe on its accept edge.
- dv_in while busy=1: ignored, no state change.
- dv_in on the cycle dv_out is high: accepted (back-to-back, no gap).
- Reset (any time, incl. mid-transfer): abort; all outputs 0, state IDLE, registers cleared.

## Timing
- Edges numbered E0 (dv_in sampled high), E1, …
- P2S: bit i on ser_out during cycle after E(i), i=0..N-1; ser_oe=1 and busy=1 over the same cycles; dv_out=1 during cycle after E(N); ser_oe=0 then.
- S2P: bit i sampled at E(i), i=0..N-1; busy=1 during cycles after E0..E(N-2); par_out, par_oe=1, dv_out=1 during cycle after E(N-1). Latency N-1 edges.
- Reset values: par_out=0, par_oe=0, ser_out=0, ser_oe=0, busy=0, dv_out=0, parity_err=0.
- ser_out is 0 whenever ser_oe=0.

## Configuration
- SPC_PARITY_EN defined: P2S appends one even-parity bit (XOR of the N data bits) during cycle after E(N); dv_out moves to cycle after E(N+1). S2P samples one extra bit at E(N); dv_out, par_out load and parity_err (1 if received parity ≠ XOR of data) in cycle after E(N); parity_err held until next S2P completion.
- Not defined: no parity cycle, TXP/RXP states absent, parity_err constant 0.

## Test plan
- P2S, MSB_FIRST=1, bit_lngt=4, par_in=14'h000B → ser_out 1,0,1,1 in cycles after E0..E3, ser_oe=1 for exactly 4 cycles, dv_out high cycle after E4.
- S2P, bit_lngt=0 (→14), ser_in stream 14'h2A5C MSB-first → par_out=14'h2A5C, par_oe=1, dv_out 1 cycle after E13.
- S2P bit_lngt=1, ser_in=1 with dv_in → par_out=14'h0001, dv_out cycle after E0, busy never high.
- P2S bit_lngt=8 with dv_in pulsed at E3 and at dv_out cycle → first ignored; second accepted back-to-back, ser_out resumes next cycle.
- rstn low at E2 of 8-bit P2S → all outputs 0 immediately; after release, new dv_in transfers correctly.
- With SPC_PARITY_EN: S2P 4 bits 1,1,0,1 + parity 0 → parity_err=1; repeat with parity 1 → parity_err=0.
